// File: rtl/difftest_batch_pkg.sv
// Shared types and helpers for the difftest commit batcher.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents: FSM state enum, the "good trap" exit code, saturating min helper.
package difftest_batch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    EXIT  = 2'd2
  } state_e;

  localparam logic [63:0] EXIT_GOOD = 64'hFFFF_FFFF_FFFF_FFFF;

  // Smaller of two unsigned values; used to clamp an emitted step to STEP_MAX.
  function automatic logic [31:0] sat_min(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/difftest_commit_adder.sv
// Sums the valid-gated per-core commit counts of one cycle.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; every valid count is consumed the cycle it is presented.
//
// Ports:
//   i_valid [NUM_CORES]        per-core count valid
//   i_cnt   [NUM_CORES*CNT_W]  packed counts, core i at [i*CNT_W +: CNT_W]
//   o_sum   [SUM_W]            total of the valid counts (SUM_W must exceed CNT_W)
module difftest_commit_adder
  import difftest_batch_pkg::*;
#(
  parameter int NUM_CORES = 1,
  parameter int CNT_W     = 4,
  parameter int SUM_W     = 17
) (
  input  logic [NUM_CORES-1:0]       i_valid,
  input  logic [NUM_CORES*CNT_W-1:0] i_cnt,
  output logic [SUM_W-1:0]           o_sum
);

  always_comb begin
    o_sum = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (i_valid[i]) begin
        o_sum = o_sum + {{(SUM_W-CNT_W){1'b0}}, i_cnt[i*CNT_W +: CNT_W]};
      end
    end
  end

endmodule

// File: rtl/difftest_step_batcher.sv
// Batches per-core commit counts into difftest_step pulses and reports the trap exit code.
// Latency: difftest_step is registered, 1 cycle after the commits that complete a batch.
// Backpressure: none; excess commits saturate the accumulator and set the sticky overflow flag.
//
// Ports:
//   i_clock, i_reset (async, active low)
//   i_commit_valid / i_commit_cnt   per-core commit counts
//   i_trap_valid / i_trap_code      single-cycle trap report (code 0 = good trap)
//   o_difftest_step                 instructions to step this cycle, 0 = none
//   o_difftest_exit                 0 = running, all-ones = good exit, else error code
//   o_acc_overflow                  sticky accumulator saturation flag
//   o_pending                       registered accumulator value
module difftest_step_batcher
  import difftest_batch_pkg::*;
#(
  parameter int NUM_CORES       = 1,
  parameter int CNT_W           = 4,
  parameter int STEPWIDTH       = 8,
  parameter int ACC_W           = 16,
  parameter int BATCH_THRESHOLD = 16,
  parameter int FLUSH_TIMEOUT   = 64
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [NUM_CORES-1:0]       i_commit_valid,
  input  logic [NUM_CORES*CNT_W-1:0] i_commit_cnt,
  input  logic                       i_trap_valid,
  input  logic [31:0]                i_trap_code,
  output logic [STEPWIDTH-1:0]       o_difftest_step,
  output logic [63:0]                o_difftest_exit,
  output logic                       o_acc_overflow,
  output logic [ACC_W-1:0]           o_pending
);

  localparam int          SUM_W      = ACC_W + 1;
  localparam int          WIDE_W     = ACC_W + 2;
  localparam int          TMR_W      = $clog2(FLUSH_TIMEOUT) + 1;
  localparam logic [31:0] STEP_MAX32 = 32'((1 << STEPWIDTH) - 1);

  state_e               r_state;
  logic [ACC_W-1:0]     r_acc;
  logic [TMR_W-1:0]     r_timer;
  logic [31:0]          r_trap_code;
  logic [STEPWIDTH-1:0] r_step;
  logic [63:0]          r_exit;
  logic                 r_ovf;

  logic [SUM_W-1:0]     w_sum;
  logic [SUM_W-1:0]     w_sum_eff;
  logic [WIDE_W-1:0]    w_acc_wide;
  logic                 w_ovf;
  logic [ACC_W-1:0]     w_acc_next;
  logic                 w_drain;
  logic                 w_emit;
  state_e               w_state_nx;
  logic [ACC_W-1:0]     w_acc_d;
  logic [TMR_W-1:0]     w_timer_d;
  logic [31:0]          w_code_d;
  logic [STEPWIDTH-1:0] w_step_d;
  logic [63:0]          w_exit_d;

  difftest_commit_adder #(
    .NUM_CORES (NUM_CORES),
    .CNT_W     (CNT_W),
    .SUM_W     (SUM_W)
  ) u_adder (
    .i_valid (i_commit_valid),
    .i_cnt   (i_commit_cnt),
    .o_sum   (w_sum)
  );

  // Only RUN accepts new commits; DRAIN and EXIT see a zero sum.
  assign w_sum_eff  = (r_state == RUN) ? w_sum : '0;
  assign w_acc_wide = {2'b00, r_acc} + {1'b0, w_sum_eff};
  assign w_ovf      = (w_acc_wide > {2'b00, {ACC_W{1'b1}}});
  assign w_acc_next = w_ovf ? {ACC_W{1'b1}} : w_acc_wide[ACC_W-1:0];

  always_comb begin
    w_state_nx = r_state;
    w_code_d   = r_trap_code;
    w_drain    = 1'b0;
    w_exit_d   = r_exit;
    w_step_d   = '0;
    w_acc_d    = w_acc_next;
    w_timer_d  = r_timer;

    case (r_state)
      RUN: begin
        // The trap cycle already drains, so the final batch (including this
        // cycle's commits) leaves immediately instead of waiting a cycle.
        if (i_trap_valid) begin
          w_drain    = 1'b1;
          w_code_d   = i_trap_code;
          w_state_nx = (w_acc_next == '0) ? EXIT : DRAIN;
        end
      end
      DRAIN: begin
        w_drain = 1'b1;
        if (w_acc_next == '0) begin
          w_state_nx = EXIT;
        end
      end
      EXIT:    w_state_nx = EXIT;
      default: w_state_nx = RUN;
    endcase

    w_emit = (r_state != EXIT) && (w_acc_next != '0) &&
             (({{(32-ACC_W){1'b0}}, w_acc_next} >= BATCH_THRESHOLD) ||
              ({{(32-TMR_W){1'b0}}, r_timer} >= FLUSH_TIMEOUT - 1) ||
              w_drain);

    if (w_emit) begin
      w_step_d  = STEPWIDTH'(sat_min({{(32-ACC_W){1'b0}}, w_acc_next}, STEP_MAX32));
      w_acc_d   = w_acc_next - ACC_W'(sat_min({{(32-ACC_W){1'b0}}, w_acc_next}, STEP_MAX32));
      w_timer_d = '0;
    end else if (w_acc_next == '0) begin
      w_timer_d = '0;
    end else if (r_timer != {TMR_W{1'b1}}) begin
      w_timer_d = r_timer + 1'b1;
    end

    // EXIT is only entered once the accumulator is empty, so the exit code is
    // always at least one cycle behind the last step pulse.
    if ((w_state_nx == EXIT) && (r_state != EXIT)) begin
      w_exit_d = (w_code_d == 32'h0) ? EXIT_GOOD : {32'h0, w_code_d};
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_acc       <= '0;
      r_timer     <= '0;
      r_trap_code <= '0;
      r_step      <= '0;
      r_exit      <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_acc       <= w_acc_d;
      r_timer     <= w_timer_d;
      r_trap_code <= w_code_d;
      r_step      <= w_step_d;
      r_exit      <= w_exit_d;
      r_ovf       <= r_ovf | w_ovf;
    end
  end

  assign o_difftest_step = r_step;
  assign o_difftest_exit = r_exit;
  assign o_acc_overflow  = r_ovf;
  assign o_pending       = r_acc;

endmodule

// File: tb/tb_difftest_step_batcher.sv
// Directed bench for difftest_step_batcher using three parameterisations.
// Latency: n/a.
// Backpressure: n/a.
module tb_difftest_step_batcher;

  logic clk;
  logic rst_n;

  // u_a: 2 cores, default parameters otherwise
  logic [1:0]  a_cv;
  logic [7:0]  a_cnt;
  logic        a_tv;
  logic [31:0] a_tc;
  logic [7:0]  a_step;
  logic [63:0] a_exit;
  logic        a_ovf;
  logic [15:0] a_pend;

  // u_b: STEPWIDTH=4, threshold 15
  logic [1:0]  b_cv;
  logic [7:0]  b_cnt;
  logic [3:0]  b_step;
  logic [63:0] b_exit;
  logic        b_ovf;
  logic [15:0] b_pend;

  // u_c: ACC_W=6, 6-bit counts, threshold unreachable
  logic [0:0]  c_cv;
  logic [5:0]  c_cnt;
  logic [7:0]  c_step;
  logic [63:0] c_exit;
  logic        c_ovf;
  logic [5:0]  c_pend;

  int n_checks = 0;
  int n_fail   = 0;

  difftest_step_batcher #(.NUM_CORES(2)) u_a (
    .i_clock(clk), .i_reset(rst_n),
    .i_commit_valid(a_cv), .i_commit_cnt(a_cnt),
    .i_trap_valid(a_tv), .i_trap_code(a_tc),
    .o_difftest_step(a_step), .o_difftest_exit(a_exit),
    .o_acc_overflow(a_ovf), .o_pending(a_pend)
  );

  difftest_step_batcher #(.NUM_CORES(2), .STEPWIDTH(4), .BATCH_THRESHOLD(15)) u_b (
    .i_clock(clk), .i_reset(rst_n),
    .i_commit_valid(b_cv), .i_commit_cnt(b_cnt),
    .i_trap_valid(1'b0), .i_trap_code(32'h0),
    .o_difftest_step(b_step), .o_difftest_exit(b_exit),
    .o_acc_overflow(b_ovf), .o_pending(b_pend)
  );

  difftest_step_batcher #(.NUM_CORES(1), .CNT_W(6), .ACC_W(6), .BATCH_THRESHOLD(64)) u_c (
    .i_clock(clk), .i_reset(rst_n),
    .i_commit_valid(c_cv), .i_commit_cnt(c_cnt),
    .i_trap_valid(1'b0), .i_trap_code(32'h0),
    .o_difftest_step(c_step), .o_difftest_exit(c_exit),
    .o_acc_overflow(c_ovf), .o_pending(c_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_cv = '0; a_cnt = '0; a_tv = 1'b0; a_tc = '0;
    b_cv = '0; b_cnt = '0;
    c_cv = '0; c_cnt = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    logic seen_step;

    rst_n = 1'b1;
    idle_inputs();
    do_reset();

    // Reset state
    check_eq("rst_step", 64'(a_step), 64'd0);
    check_eq("rst_exit", a_exit, 64'd0);
    check_eq("rst_ovf",  64'(a_ovf),  64'd0);
    check_eq("rst_pend", 64'(a_pend), 64'd0);

    // Threshold batching: 4 x cnt=4 on core 0 -> step 16 after the 4th cycle
    a_cv = 2'b01; a_cnt = 8'h04;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("thr_step_%0d", i), 64'(a_step), 64'd0);
    end
    check_eq("thr_pend_12", 64'(a_pend), 64'd12);
    tick();
    a_cv = '0; a_cnt = '0;
    check_eq("thr_step_16", 64'(a_step), 64'd16);
    check_eq("thr_pend_0", 64'(a_pend), 64'd0);
    tick();
    check_eq("thr_step_after", 64'(a_step), 64'd0);

    // Timeout flush: one commit of 3 then idle -> step 3 FLUSH_TIMEOUT cycles later
    do_reset();
    a_cv = 2'b10; a_cnt = 8'h30;
    tick();
    a_cv = '0; a_cnt = '0;
    n = 1;
    while (a_step == 8'd0 && n < 200) begin
      tick();
      n++;
    end
    check_eq("tmo_cycles", 64'(n), 64'd64);
    check_eq("tmo_step", 64'(a_step), 64'd3);
    check_eq("tmo_pend", 64'(a_pend), 64'd0);

    // Step clamp with carry on u_b: 15+15 -> 15 then 15
    do_reset();
    b_cv = 2'b11; b_cnt = 8'hFF;
    tick();
    b_cv = '0; b_cnt = '0;
    check_eq("clamp_step1", 64'(b_step), 64'd15);
    check_eq("clamp_pend1", 64'(b_pend), 64'd15);
    tick();
    check_eq("clamp_step2", 64'(b_step), 64'd15);
    check_eq("clamp_pend2", 64'(b_pend), 64'd0);
    tick();
    check_eq("clamp_step3", 64'(b_step), 64'd0);

    // Good trap drain: acc=5, trap (code 0) with cnt=2 in the same cycle
    do_reset();
    a_cv = 2'b01; a_cnt = 8'h05;
    tick();
    check_eq("gt_pend5", 64'(a_pend), 64'd5);
    a_cv = 2'b01; a_cnt = 8'h02; a_tv = 1'b1; a_tc = 32'h0;
    tick();
    a_cv = '0; a_cnt = '0; a_tv = 1'b0;
    check_eq("gt_step7", 64'(a_step), 64'd7);
    check_eq("gt_exit_not_yet", a_exit, 64'd0);
    tick();
    check_eq("gt_step0", 64'(a_step), 64'd0);
    check_eq("gt_exit", a_exit, 64'hFFFF_FFFF_FFFF_FFFF);
    // Later commits and a second trap are ignored
    a_cv = 2'b11; a_cnt = 8'hFF; a_tv = 1'b1; a_tc = 32'h55;
    tick();
    a_tv = 1'b0;
    tick();
    tick();
    check_eq("gt_late_step", 64'(a_step), 64'd0);
    check_eq("gt_late_pend", 64'(a_pend), 64'd0);
    check_eq("gt_exit_held", a_exit, 64'hFFFF_FFFF_FFFF_FFFF);
    a_cv = '0; a_cnt = '0;

    // Error trap with nothing pending: exit=0x2A within 2 cycles, no step
    do_reset();
    a_tv = 1'b1; a_tc = 32'h2A;
    seen_step = 1'b0;
    tick();
    a_tv = 1'b0; a_tc = '0;
    if (a_step != 8'd0) seen_step = 1'b1;
    if (a_exit != 64'h2A) begin
      tick();
      if (a_step != 8'd0) seen_step = 1'b1;
    end
    check_eq("et_exit", a_exit, 64'h2A);
    check_eq("et_no_step", 64'(seen_step), 64'd0);

    // Overflow on u_c: 40 + 40 saturates at 63
    c_cv = 1'b1; c_cnt = 6'd40;
    tick();
    check_eq("ovf_pend40", 64'(c_pend), 64'd40);
    check_eq("ovf_flag0", 64'(c_ovf), 64'd0);
    tick();
    c_cv = '0; c_cnt = '0;
    check_eq("ovf_pend63", 64'(c_pend), 64'd63);
    check_eq("ovf_flag1", 64'(c_ovf), 64'd1);
    check_eq("ovf_step0", 64'(c_step), 64'd0);

    // Asynchronous reset mid-cycle clears outputs without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_c_pend", 64'(c_pend), 64'd0);
    check_eq("arst_c_ovf", 64'(c_ovf), 64'd0);
    check_eq("arst_a_exit", a_exit, 64'd0);
    check_eq("arst_a_step", 64'(a_step), 64'd0);
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/difftest_step_batcher.md
Name: difftest_step_batcher

Overview:
- Sits directly upstream of the simulation endpoint.
- Collects per-core, per-cycle commit counts and the trap event from the DUT difftest probes.
- Batches commits into the `difftest_step` pulse and drives the 64-bit `difftest_exit` code the endpoint checks.
- Trap reporting is ordered: every committed instruction is stepped before the exit code becomes visible.

Parameters:
- NUM_CORES, 1: number of cores reporting commits.
- CNT_W, 4: width of each core's per-cycle commit count.
- STEPWIDTH, 8: width of `difftest_step`; STEP_MAX = 2^STEPWIDTH-1.
- ACC_W, 16: accumulator width; ACC_MAX = 2^ACC_W-1.
- BATCH_THRESHOLD, 16: an accumulated count >= this emits a step.
- FLUSH_TIMEOUT, 64: idle cycles with a nonzero accumulator before a forced step.

Ports:
- clock, in, 1: sole clock.
- reset, in, 1: asynchronous, active-low reset (asserted when 0).
- commit_valid, in, NUM_CORES: per-core commit-count valid.
- commit_cnt, in, NUM_CORES*CNT_W: packed counts; core i uses bits [i*CNT_W +: CNT_W].
- trap_valid, in, 1: single-cycle trap report.
- trap_code, in, 32: 0 = good trap; nonzero = error code.
- difftest_step, out, STEPWIDTH: instructions to step this cycle; 0 = no step.
- difftest_exit, out, 64: 0 = running; all-ones = normal exit; otherwise error code.
- acc_overflow, out, 1: sticky; the accumulator saturated.
- pending, out, ACC_W: current accumulator value, for debug.

Behaviour:
- Reset (async, low):
  - difftest_step=0, difftest_exit=0, acc_overflow=0, pending=0.
  - Accumulator, timer and trap latch cleared; state=RUN.
- Per-cycle sum:
  - sum = Σ over valid cores of commit_cnt[i], computed at ACC_W+1 bits.
  - acc_next = acc + sum. If this exceeds ACC_MAX, clamp to ACC_MAX and set acc_overflow (sticky until reset).
- Emit condition, evaluated on acc_next: acc_next>0 AND (acc_next>=BATCH_THRESHOLD OR timer>=FLUSH_TIMEOUT-1 OR state==DRAIN).
- On emit:
  - difftest_step <= min(acc_next, STEP_MAX), registered, so it appears 1 cycle after the inputs.
  - acc <= acc_next - that amount; the remainder carries to the next cycle.
  - timer <= 0.
- Otherwise: difftest_step <= 0; acc <= acc_next; timer increments while acc_next>0 (saturating) and resets to 0 when acc_next==0.
- difftest_step is a one-cycle value, never held across cycles except on consecutive emits.
- States:
  - RUN: normal batching. On trap_valid, latch trap_code and go to DRAIN. Commits in the trap cycle are still summed.
  - DRAIN: forced emit every cycle while acc_next>0. New commit_valid inputs are ignored (sum forced to 0). When acc_next==0, go to EXIT.
  - EXIT: difftest_exit <= (latched code==0) ? 64'hFFFF_FFFF_FFFF_FFFF : {32'h0, code}. It is driven from the cycle after entry and held until reset. Commits and traps are ignored; difftest_step=0.
- Ordering guarantee: the last nonzero difftest_step precedes the first nonzero difftest_exit by >=1 cycle.
- Edge cases:
  - A trap with acc_next==0 in the trap cycle goes straight to EXIT.
  - A second trap_valid in DRAIN/EXIT is ignored; the first code wins.
  - Reset mid-DRAIN aborts the batch and drops the pending count.
- pending mirrors the registered acc.

Decomposition:
- Package difftest_batch_pkg:
  - state enum {RUN, DRAIN, EXIT}.
  - EXIT_GOOD = 64'hFFFF_FFFF_FFFF_FFFF.
  - Helper function for saturating min.
- Sub-module difftest_commit_adder: a combinational/registered-free adder tree summing NUM_CORES valid-gated counts.
- Everything else stays in the top.

Test Plan:
- Threshold batching: 1 core, cnt=4 valid for 4 cycles → acc_next=16 on the 4th cycle, so step=16 in the following cycle; all other cycles step=0.
- Timeout flush: single commit cnt=3, then idle → step=3 exactly FLUSH_TIMEOUT cycles after the commit; pending returns to 0.
- Step clamp with carry: STEPWIDTH=4, cnt=15 from 2 cores in one cycle (sum 30) → step=15 (threshold met), next cycle step=15, pending=0.
- Good trap drain: acc=5, trap_valid with code 0 and cnt=2 → step=7 next cycle, then exit=all-ones the cycle after, held; later commits produce step=0.
- Error trap with no pending: acc=0, trap code 0x2A → difftest_exit=0x2A within 2 cycles; no step pulse emitted.
- Overflow and async reset: ACC_W=6, inject sum 40 then 40 → pending clamps at 63, acc_overflow=1; reset pulled low mid-cycle clears all outputs immediately without waiting for a clock edge.
